// File: rtl/hline_zbuff_pkg.sv
// Shared types and defaults for the horizontal-line z-buffer pipeline.
package hline_zbuff_pkg;

  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned Z_BYTES_DEF  = 4;
  localparam int unsigned FB_BYTES_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    ZRD,
    CMP,
    ZWR_REQ,
    ZWR,
    FWR_REQ,
    FWR
  } state_t;

  // Byte address of pixel (y, x) in a row-major surface; wraps mod 2^32.
  function automatic logic [31:0] span_addr(input logic [31:0] base,
                                            input logic [31:0] y,
                                            input logic [15:0] x,
                                            input logic [31:0] stride,
                                            input logic [31:0] bpp);
    logic [31:0] pix;
    pix = y * stride + {16'h0000, x};
    return base + pix * bpp;
  endfunction

endpackage

// File: rtl/hline_zbuff_fsm_if.sv
// Control/data bundle between the line FSM and its FIFOs/AXI sequencer.
interface hline_zbuff_fsm_if;
  logic        start;
  logic [31:0] fb_addr;
  logic [31:0] zbuff_addr;
  logic [31:0] y;
  logic [15:0] x1;
  logic [15:0] x2;
  logic [31:0] slope;
  logic [31:0] z1;
  logic [31:0] z2;
  logic [31:0] rem;
  logic [31:0] err;
  logic        zread_empty;
  logic [31:0] zfifo_in;
  logic        axi_done;

  logic        rd_req;
  logic        wr_req;
  logic [31:0] addr;
  logic [1:0]  byteenable;
  logic        read_zfifo;
  logic        write_zfifo;
  logic [31:0] z_out;
  logic        read_zbuffout_fifo;
  logic        read_be_fifo;

  modport master (
    input  start, fb_addr, zbuff_addr, y, x1, x2, slope, z1, z2, rem, err,
           zread_empty, zfifo_in, axi_done,
    output rd_req, wr_req, addr, byteenable, read_zfifo, write_zfifo, z_out,
           read_zbuffout_fifo, read_be_fifo
  );

  modport slave (
    output start, fb_addr, zbuff_addr, y, x1, x2, slope, z1, z2, rem, err,
           zread_empty, zfifo_in, axi_done,
    input  rd_req, wr_req, addr, byteenable, read_zfifo, write_zfifo, z_out,
           read_zbuffout_fifo, read_be_fifo
  );
endinterface

// File: rtl/hline_zinterp.sv
// Bresenham-style z interpolator: integer slope plus carried fractional rem/span.
module hline_zinterp (
  input  logic        clk,
  input  logic        nreset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] z1,
  input  logic [31:0] err,
  input  logic [31:0] slope,
  input  logic [31:0] rem,
  input  logic [15:0] span,
  output logic [31:0] z_cur
);

  logic [31:0] e;
  logic [31:0] e_sum;
  logic        carry;

  // A zero-length span never carries, even though e+rem >= 0 always holds.
  always_comb begin
    e_sum = e + rem;
    carry = (span != '0) && (e_sum >= {16'h0000, span});
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      z_cur <= '0;
      e     <= '0;
    end else if (load) begin
      z_cur <= z1;
      e     <= err;
    end else if (step) begin
      if (carry) begin
        z_cur <= z_cur + slope + 32'd1;
        e     <= e_sum - {16'h0000, span};
      end else begin
        z_cur <= z_cur + slope;
        e     <= e_sum;
      end
    end
  end

endmodule

// File: rtl/hline_zbuff_fsm.sv
// Horizontal-line z-buffer controller: span read, per-pixel depth test,
// then z-buffer and framebuffer write-back sequencing.
module hline_zbuff_fsm
  import hline_zbuff_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned Z_BYTES  = Z_BYTES_DEF,
  parameter int unsigned FB_BYTES = FB_BYTES_DEF
) (
  input  logic               clk,
  input  logic               nreset,
  hline_zbuff_fsm_if.master  bus
);

  state_t      state;
  state_t      next_state;

  logic        axi_done_d;
  logic        axi_evt;

  logic [15:0] span_q;
  logic [31:0] slope_q;
  logic [31:0] z1_q;
  logic [31:0] rem_q;
  logic [31:0] err_q;
  logic [31:0] zaddr_q;
  logic [31:0] faddr_q;
  logic [31:0] zaddr_in;
  logic [31:0] faddr_in;
  logic [31:0] addr_q;
  logic [15:0] cnt;

  logic        pop;
  logic        pass;
  logic [31:0] z_cur;

  assign zaddr_in = span_addr(bus.zbuff_addr, bus.y, bus.x1, 32'(SCREEN_W), 32'(Z_BYTES));
  assign faddr_in = span_addr(bus.fb_addr,    bus.y, bus.x1, 32'(SCREEN_W), 32'(FB_BYTES));

  assign axi_evt = bus.axi_done & ~axi_done_d;
  assign pop     = (state == CMP) && !bus.zread_empty;
  assign pass    = z_cur < bus.zfifo_in;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.start && (bus.x2 >= bus.x1)) next_state = ZRD;
      ZRD:     next_state = CMP;
      CMP:     if (pop && (cnt == span_q)) next_state = ZWR_REQ;
      ZWR_REQ: next_state = ZWR;
      ZWR:     if (axi_evt) next_state = FWR_REQ;
      FWR_REQ: next_state = FWR;
      FWR:     if (axi_evt) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_req             = 1'b0;
    bus.wr_req             = 1'b0;
    bus.addr               = addr_q;
    bus.read_zfifo         = 1'b0;
    bus.write_zfifo        = 1'b0;
    bus.z_out              = '0;
    bus.byteenable         = '0;
    bus.read_zbuffout_fifo = 1'b0;
    bus.read_be_fifo       = 1'b0;
    unique case (state)
      ZRD:              bus.rd_req = 1'b1;
      ZWR_REQ, FWR_REQ: bus.wr_req = 1'b1;
      ZWR:              bus.read_zbuffout_fifo = 1'b1;
      FWR:              bus.read_be_fifo = 1'b1;
      CMP: begin
        if (pop) begin
          bus.read_zfifo  = 1'b1;
          bus.write_zfifo = 1'b1;
          bus.z_out       = pass ? z_cur : bus.zfifo_in;
          bus.byteenable  = pass ? 2'b11 : 2'b00;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      axi_done_d <= 1'b0;
    end else begin
      axi_done_d <= bus.axi_done;
    end
  end

  // Line parameters are captured on any start seen in IDLE; they are only
  // consumed once the FSM leaves IDLE, so a rejected x2<x1 start is harmless.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      span_q  <= '0;
      slope_q <= '0;
      z1_q    <= '0;
      rem_q   <= '0;
      err_q   <= '0;
      zaddr_q <= '0;
      faddr_q <= '0;
    end else if ((state == IDLE) && bus.start) begin
      span_q  <= bus.x2 - bus.x1;
      slope_q <= bus.slope;
      z1_q    <= bus.z1;
      rem_q   <= bus.rem;
      err_q   <= bus.err;
      zaddr_q <= zaddr_in;
      faddr_q <= faddr_in;
    end
  end

  // The read address is taken straight from the inputs because the latched
  // copy only becomes valid on the same edge that enters ZRD.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      addr_q <= '0;
    end else if (state != next_state) begin
      unique case (next_state)
        ZRD:     addr_q <= zaddr_in;
        ZWR_REQ: addr_q <= zaddr_q;
        FWR_REQ: addr_q <= faddr_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (state == ZRD) begin
      cnt <= '0;
    end else if (pop) begin
      cnt <= cnt + 16'd1;
    end
  end

  hline_zinterp u_zinterp (
    .clk    (clk),
    .nreset (nreset),
    .load   (state == ZRD),
    .step   (pop),
    .z1     (z1_q),
    .err    (err_q),
    .slope  (slope_q),
    .rem    (rem_q),
    .span   (span_q),
    .z_cur  (z_cur)
  );

endmodule

// File: tb/tb_hline_zbuff_fsm.sv
// Scoreboard bench for hline_zbuff_fsm: expected requests and pixel pushes
// are queued at stimulus time and retired by a negedge monitor.
module tb_hline_zbuff_fsm;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  hline_zbuff_fsm_if bus ();

  hline_zbuff_fsm #(
    .SCREEN_W (640),
    .Z_BYTES  (4),
    .FB_BYTES (2)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
  } req_t;

  typedef struct {
    logic [31:0] z;
    logic [1:0]  be;
  } pix_t;

  req_t req_q[$];
  pix_t pix_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   push_cnt   = 0;
  bit   toggle_en  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_addr(input logic [31:0] base, input logic [31:0] yy,
                                           input logic [15:0] xx, input logic [31:0] bpp);
    return base + (yy * 32'd640 + {16'd0, xx}) * bpp;
  endfunction

  // Reference interpolation and depth test against a constant stored z.
  task automatic model_line(input logic [15:0] a, input logic [15:0] b, input logic [31:0] sl,
                            input logic [31:0] zz1, input logic [31:0] rm, input logic [31:0] er,
                            input logic [31:0] zin);
    logic [15:0] sp;
    logic [31:0] z, e, s;
    pix_t        p;
    sp = b - a;
    z  = zz1;
    e  = er;
    for (int unsigned i = 0; i <= 32'(sp); i++) begin
      p.z  = (z < zin) ? z : zin;
      p.be = (z < zin) ? 2'b11 : 2'b00;
      pix_q.push_back(p);
      s = e + rm;
      if (sp != 16'd0 && s >= {16'd0, sp}) begin
        z = z + sl + 32'd1;
        e = s - {16'd0, sp};
      end else begin
        z = z + sl;
        e = s;
      end
    end
  endtask

  task automatic expect_reqs(input logic [31:0] za, input logic [31:0] fa);
    req_t r;
    r.wr = 1'b0; r.addr = za; req_q.push_back(r);
    r.wr = 1'b1; r.addr = za; req_q.push_back(r);
    r.wr = 1'b1; r.addr = fa; req_q.push_back(r);
  endtask

  task automatic drive_line(input logic [31:0] fb, input logic [31:0] zb, input logic [31:0] yy,
                            input logic [15:0] a, input logic [15:0] b, input logic [31:0] sl,
                            input logic [31:0] zz1, input logic [31:0] rm, input logic [31:0] er,
                            input logic [31:0] zin);
    bus.fb_addr    = fb;
    bus.zbuff_addr = zb;
    bus.y          = yy;
    bus.x1         = a;
    bus.x2         = b;
    bus.slope      = sl;
    bus.z1         = zz1;
    bus.z2         = zz1 + sl;
    bus.rem        = rm;
    bus.err        = er;
    bus.zfifo_in   = zin;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // sel: 1 read_zbuffout_fifo high, 2 read_be_fifo high, 3 read_be_fifo low, 4 write_zfifo high
  task automatic wait_for(input int sel, input int budget, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk); #1;
      if (toggle_en) bus.zread_empty = ~bus.zread_empty;
      case (sel)
        1: hit = bus.read_zbuffout_fifo;
        2: hit = bus.read_be_fifo;
        3: hit = !bus.read_be_fifo;
        default: hit = bus.write_zfifo;
      endcase
    end
    chk({"wait_", tag}, 32'(hit), 32'd1);
  endtask

  task automatic finish_wb(input string tag);
    bus.axi_done = 1'b1;
    @(posedge clk); #1;
    bus.axi_done = 1'b0;
    wait_for(2, 20, {tag, "_fwr"});
    bus.axi_done = 1'b1;
    @(posedge clk); #1;
    bus.axi_done = 1'b0;
    wait_for(3, 20, {tag, "_idle"});
  endtask

  always @(negedge clk) begin
    req_t r;
    pix_t p;
    if (bus.rd_req || bus.wr_req) begin
      if (req_q.size() == 0) begin
        chk("spurious_req", 32'(bus.rd_req | bus.wr_req), 32'd0);
      end else begin
        r = req_q.pop_front();
        chk("req_is_wr", 32'(bus.wr_req), 32'(r.wr));
        chk("req_one_hot", 32'(bus.rd_req ^ bus.wr_req), 32'd1);
        chk("req_addr", bus.addr, r.addr);
      end
    end
    if (bus.write_zfifo || bus.read_zfifo) begin
      push_cnt++;
      chk("pop_with_push", 32'(bus.read_zfifo), 32'(bus.write_zfifo));
      chk("push_while_empty", 32'(bus.zread_empty), 32'd0);
      if (pix_q.size() == 0) begin
        chk("spurious_push", 32'(bus.write_zfifo), 32'd0);
      end else begin
        p = pix_q.pop_front();
        chk("z_out", bus.z_out, p.z);
        chk("byteenable", 32'(bus.byteenable), 32'(p.be));
      end
    end
  end

  int pc0;

  initial begin
    nreset          = 1'b0;
    bus.start       = 1'b0;
    bus.zread_empty = 1'b0;
    bus.axi_done    = 1'b0;
    drive_line(32'h0, 32'h0, 32'h0, 16'd0, 16'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_req", 32'(bus.rd_req), 32'd0);
    chk("rst_wr_req", 32'(bus.wr_req), 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_write_zfifo", 32'(bus.write_zfifo), 32'd0);
    chk("rst_read_zfifo", 32'(bus.read_zfifo), 32'd0);
    chk("rst_z_out", bus.z_out, 32'd0);
    chk("rst_byteenable", 32'(bus.byteenable), 32'd0);
    chk("rst_read_zbuffout", 32'(bus.read_zbuffout_fifo), 32'd0);
    chk("rst_read_be", 32'(bus.read_be_fifo), 32'd0);
    nreset = 1'b1;
    @(posedge clk); #1;

    // Full line, 257 pixels, with axi_done held as a level across phases.
    drive_line(32'h0, 32'h1000_0000, 32'h1234, 16'd0, 16'd256, 32'h00ff_ffff,
               32'h0, 32'd255, 32'd128, 32'hffff_ffff);
    model_line(16'd0, 16'd256, 32'h00ff_ffff, 32'h0, 32'd255, 32'd128, 32'hffff_ffff);
    expect_reqs(32'h10B6_0800, 32'h005B_0400);
    pc0 = push_cnt;
    pulse_start();
    wait_for(1, 400, "full_zwr");
    chk("full_push_count", 32'(push_cnt - pc0), 32'd257);
    repeat (2) begin
      @(posedge clk); #1;
      chk("full_zwr_hold", 32'(bus.read_zbuffout_fifo), 32'd1);
    end
    bus.axi_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("full_fwr_level", 32'(bus.read_be_fifo), 32'd1);
    bus.axi_done = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("full_fwr_hold", 32'(bus.read_be_fifo), 32'd1);
    end
    bus.axi_done = 1'b1;
    @(posedge clk); #1;
    chk("full_fwr_end", 32'(bus.read_be_fifo), 32'd0);
    chk("full_idle_zwr", 32'(bus.read_zbuffout_fifo), 32'd0);
    bus.axi_done = 1'b0;
    @(posedge clk); #1;

    // Same line with zread_empty toggling every cycle.
    drive_line(32'h0, 32'h1000_0000, 32'h1234, 16'd0, 16'd256, 32'h00ff_ffff,
               32'h0, 32'd255, 32'd128, 32'hffff_ffff);
    model_line(16'd0, 16'd256, 32'h00ff_ffff, 32'h0, 32'd255, 32'd128, 32'hffff_ffff);
    expect_reqs(32'h10B6_0800, 32'h005B_0400);
    pc0 = push_cnt;
    pulse_start();
    toggle_en = 1'b1;
    wait_for(1, 1000, "stall_zwr");
    toggle_en = 1'b0;
    bus.zread_empty = 1'b0;
    chk("stall_push_count", 32'(push_cnt - pc0), 32'd257);
    finish_wb("stall");

    // Depth fail everywhere; a start arriving while busy is ignored.
    drive_line(32'h2000_0000, 32'h3000_0000, 32'd5, 16'd3, 16'd12, 32'd7,
               32'd100, 32'd3, 32'd0, 32'h0);
    model_line(16'd3, 16'd12, 32'd7, 32'd100, 32'd3, 32'd0, 32'h0);
    expect_reqs(ref_addr(32'h3000_0000, 32'd5, 16'd3, 32'd4),
                ref_addr(32'h2000_0000, 32'd5, 16'd3, 32'd2));
    pulse_start();
    wait_for(1, 100, "fail_zwr");
    drive_line(32'h0, 32'h0, 32'd1, 16'd0, 16'd3, 32'd1, 32'd1, 32'd0, 32'd0, 32'h0);
    pulse_start();
    finish_wb("fail");

    // Mixed pass/fail around a stored z inside the ramp.
    drive_line(32'h0040_0000, 32'h0080_0000, 32'd479, 16'd100, 16'd120, 32'h40,
               32'h100, 32'd5, 32'd3, 32'h500);
    model_line(16'd100, 16'd120, 32'h40, 32'h100, 32'd5, 32'd3, 32'h500);
    expect_reqs(ref_addr(32'h0080_0000, 32'd479, 16'd100, 32'd4),
                ref_addr(32'h0040_0000, 32'd479, 16'd100, 32'd2));
    pulse_start();
    wait_for(1, 100, "mix_zwr");
    finish_wb("mix");

    // Single-pixel span (x1 == x2).
    drive_line(32'h0, 32'h0, 32'd2, 16'd7, 16'd7, 32'd9, 32'h55, 32'hffff_ffff,
               32'h10, 32'h56);
    model_line(16'd7, 16'd7, 32'd9, 32'h55, 32'hffff_ffff, 32'h10, 32'h56);
    expect_reqs(ref_addr(32'h0, 32'd2, 16'd7, 32'd4), ref_addr(32'h0, 32'd2, 16'd7, 32'd2));
    pc0 = push_cnt;
    pulse_start();
    wait_for(1, 20, "one_zwr");
    chk("one_push_count", 32'(push_cnt - pc0), 32'd1);
    finish_wb("one");

    // x2 < x1: no requests at all.
    drive_line(32'h0, 32'h0, 32'd1, 16'd10, 16'd5, 32'd1, 32'd1, 32'd0, 32'd0, 32'h10);
    pc0 = push_cnt;
    pulse_start();
    repeat (6) @(posedge clk);
    #1;
    chk("rev_no_push", 32'(push_cnt - pc0), 32'd0);
    chk("rev_no_zwr", 32'(bus.read_zbuffout_fifo), 32'd0);

    // Reset in the middle of CMP.
    drive_line(32'h0, 32'h0400_0000, 32'd9, 16'd0, 16'd19, 32'd3, 32'd1, 32'd1,
               32'd0, 32'hffff_ffff);
    model_line(16'd0, 16'd19, 32'd3, 32'd1, 32'd1, 32'd0, 32'hffff_ffff);
    expect_reqs(ref_addr(32'h0400_0000, 32'd9, 16'd0, 32'd4), ref_addr(32'h0, 32'd9, 16'd0, 32'd2));
    pulse_start();
    wait_for(4, 20, "rst_cmp");
    repeat (3) @(posedge clk);
    #1;
    nreset = 1'b0;
    #1;
    chk("midrst_write_zfifo", 32'(bus.write_zfifo), 32'd0);
    chk("midrst_read_zfifo", 32'(bus.read_zfifo), 32'd0);
    chk("midrst_z_out", bus.z_out, 32'd0);
    chk("midrst_req", 32'(bus.rd_req | bus.wr_req), 32'd0);
    req_q.delete();
    pix_q.delete();
    pc0 = push_cnt;
    @(posedge clk); #1;
    nreset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_push", 32'(push_cnt - pc0), 32'd0);
    chk("midrst_no_zwr", 32'(bus.read_zbuffout_fifo | bus.read_be_fifo), 32'd0);

    chk("sb_req_drained", 32'(req_q.size()), 32'd0);
    chk("sb_pix_drained", 32'(pix_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
